// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl -- bit-serial adder controller around a single full adder.
//
// Purpose:
//   Adds two WIDTH-bit unsigned operands plus a carry-in, one bit per clock,
//   through one full_adder cell. The running carry lives in a flip-flop and
//   the result is assembled in a shift register. A start/done handshake
//   frames each add.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   request; accepted only in IDLE or in the DONE cycle
//   a, b   in   WIDTH-bit operands, captured on the accepting edge
//   cin    in   carry-in, captured on the accepting edge
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse when sum/cout are updated
//   sum    out  registered WIDTH-bit result, held until the next completion
//   cout   out  registered final carry, held with sum

module full_adder (
  input  logic x,
  input  logic y,
  input  logic d,
  output logic sum,
  output logic cout
);
  assign sum  = x ^ y ^ d;
  assign cout = (x & y) | (d & (x ^ y));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] sha_reg;
  logic [WIDTH-1:0] shb_reg;
  logic [WIDTH-1:0] shs_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;

  logic fa_sum;
  logic fa_cout;
  logic load;

  // The single adder cell sees the current LSBs and the carry flop.
  full_adder u_fa (
    .x    (sha_reg[0]),
    .y    (shb_reg[0]),
    .d    (carry_reg),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // start is only honoured when no add is in flight; the DONE cycle counts
  // as free so back-to-back adds lose no extra cycle.
  assign load = start && ((state_reg == IDLE) || (state_reg == DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sha_reg   <= '0;
      shb_reg   <= '0;
      shs_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else if (load) begin
      sha_reg   <= a;
      shb_reg   <= b;
      shs_reg   <= '0;
      carry_reg <= cin;
      cnt_reg   <= '0;
      state_reg <= RUN;
    end else begin
      case (state_reg)
        RUN: begin
          carry_reg <= fa_cout;
          // Result bits enter at the top so after WIDTH shifts the first
          // (least significant) bit has reached position 0.
          shs_reg   <= {fa_sum, shs_reg[WIDTH-1:1]};
          sha_reg   <= {1'b0, sha_reg[WIDTH-1:1]};
          shb_reg   <= {1'b0, shb_reg[WIDTH-1:1]};
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_BIT) begin
            sum_reg   <= {fa_sum, shs_reg[WIDTH-1:1]};
            cout_reg  <= fa_cout;
            state_reg <= DONE;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  // 4-bit instance for the exhaustive sweep
  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic on the operands.
  function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
    int s;
    s = int'(x) + int'(y) + int'(c);
    return s[8:0];
  endfunction

  function automatic logic [4:0] model4(input int x, input int y, input int c);
    int s;
    s = x + y + c;
    return s[4:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one 8-bit add (caller sits just after a posedge), wait for done.
  // Returns the result, edges from accept to done, and busy cycles seen.
  task automatic run8(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                      output logic [8:0] res, output int lat, output int busy_cnt);
    start8 = 1'b1; a8 = xa; b8 = xb; cin8 = xc;
    tick();
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    lat = 0;
    busy_cnt = 0;
    while (!done8 && lat < 50) begin
      if (busy8) busy_cnt++;
      tick();
      lat++;
    end
    res = {cout8, sum8};
  endtask

  logic [8:0] res, prev;
  int lat, bc, ndone;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'h0F, 8'h01, 1'b0, 9'h010};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 9'h100};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 9'h000};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 9'h001};
    vecs[5] = '{8'hAA, 8'h55, 1'b0, 9'h0FF};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 9'h100};
    vecs[7] = '{8'h80, 8'h80, 1'b0, 9'h100};

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (3) tick();
    check("reset_busy8", busy8, 0);
    check("reset_done8", done8, 0);
    check("reset_sum8", {cout8, sum8}, 0);
    check("reset_done4", done4, 0);
    rst = 1'b0;
    tick();

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].cin, res, lat, bc);
      $display("[TB] vec %0d: %h+%h+%0d -> %h (exp %h) lat=%0d", i, vecs[i].a, vecs[i].b,
               vecs[i].cin, res, vecs[i].exp, lat);
      check("vec_result", res, vecs[i].exp);
      check("vec_latency", lat, 8);
      check("vec_busy_cycles", bc, 8);
      tick();
      check("vec_done_width", done8, 0);
    end

    // Randomized adds against the model
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      logic rc;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      run8(ra, rb, rc, res, lat, bc);
      $display("[TB] rnd %0d: %h+%h+%0d -> %h (exp %h)", i, ra, rb, rc, res, model8(ra, rb, rc));
      check("rnd_result", res, model8(ra, rb, rc));
      check("rnd_latency", lat, 8);
      tick();
    end

    // Start while busy is ignored; previous result held during RUN
    prev = {cout8, sum8};
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
    tick();
    start8 = 1'b0;
    lat = 0;
    repeat (2) begin tick(); lat++; end
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    tick(); lat++;
    start8 = 1'b0;
    check("busy_ignore_busy", busy8, 1);
    check("busy_ignore_held", {cout8, sum8}, prev);
    while (!done8 && lat < 50) begin tick(); lat++; end
    $display("[TB] start-while-busy: 12+34 -> %h lat=%0d", {cout8, sum8}, lat);
    check("busy_ignore_latency", lat, 8);
    check("busy_ignore_result", {cout8, sum8}, 9'h046);
    ndone = 0;
    repeat (12) begin tick(); if (done8) ndone++; end
    check("busy_ignore_single_done", ndone, 0);

    // Back-to-back: restart in the done cycle
    run8(8'h0F, 8'h01, 1'b0, res, lat, bc);
    check("b2b_first", res, 9'h010);
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
    tick();
    start8 = 1'b0;
    lat = 1;
    check("b2b_busy_rise", busy8, 1);
    check("b2b_no_done", done8, 0);
    while (!done8 && lat < 50) begin tick(); lat++; end
    $display("[TB] back-to-back: 80+80 -> %h gap=%0d", {cout8, sum8}, lat);
    check("b2b_gap", lat, 9);
    check("b2b_result", {cout8, sum8}, 9'h100);
    tick();

    // Reset mid-operation
    run8(8'h21, 8'h10, 1'b1, res, lat, bc);
    check("pre_reset_result", res, 9'h032);
    tick();
    start8 = 1'b1; a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("[TB] mid-run reset: busy=%0d sum=%h", busy8, {cout8, sum8});
    check("midrst_busy", busy8, 0);
    check("midrst_done", done8, 0);
    check("midrst_sum", {cout8, sum8}, 0);
    ndone = 0;
    repeat (12) begin tick(); if (done8) ndone++; end
    check("midrst_no_done", ndone, 0);
    run8(8'h05, 8'h03, 1'b0, res, lat, bc);
    check("post_reset_result", res, 9'h008);
    check("post_reset_latency", lat, 8);
    tick();

    // WIDTH=4 exhaustive sweep
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          start4 = 1'b1; a4 = 4'(ai); b4 = 4'(bi); cin4 = 1'(ci);
          tick();
          start4 = 1'b0;
          a4 = 4'($urandom); b4 = 4'($urandom);
          lat = 0;
          while (!done4 && lat < 20) begin tick(); lat++; end
          $display("[TB] w4: %0d+%0d+%0d -> %0d lat=%0d", ai, bi, ci, {cout4, sum4}, lat);
          check("w4_result", {cout4, sum4}, model4(ai, bi, ci));
          check("w4_latency", lat, 4);
          tick();
          check("w4_done_width", done4, 0);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
